// File: rtl/gray_pkg.sv
// Shared constants and binary/Gray conversion helpers for the Gray counter.
// The helpers work on 32-bit vectors; the width argument marks the live bits.
package gray_pkg;

  localparam int GRAY_DEFAULT_WIDTH = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] b, input int w);
    logic [31:0] g;
    g = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w - 1)       g[i] = b[i] ^ b[i+1];
      else if (i == w - 1) g[i] = b[i];
    end
    return g;
  endfunction

  // Each binary bit is the XOR of its Gray bit and the binary bit above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
    logic [31:0] b;
    b = '0;
    if (w > 31) b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      if (i < w) b[i] = g[i] ^ b[i+1];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_encode.sv
// Combinational binary-to-Gray encoder, one XOR per bit.
module gray_encode #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray[WIDTH-1] = bin[WIDTH-1];

  for (genvar i = 0; i < WIDTH - 1; i++) begin : g_bit
    assign gray[i] = bin[i] ^ bin[i+1];
  end

endmodule

// File: rtl/gray_counter.sv
// Up/down Gray counter with synchronous Gray-coded load and a registered
// wrap pulse; binary and Gray views are registered on the same edge.
module gray_counter
  import gray_pkg::*;
#(
  parameter int               WIDTH = GRAY_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic             wrap
);

  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_d;
  logic             wrap_d;
  logic             wrap_q;

  // Priority: load, then count, then hold.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = WIDTH'(gray2bin(32'(load_gray), WIDTH));
    end else if (en) begin
      if (up) begin
        bin_d  = bin_q + 1'b1;
        wrap_d = &bin_q;
      end else begin
        bin_d  = bin_q - 1'b1;
        wrap_d = ~|bin_q;
      end
    end
  end

  // Gray register follows the next binary value, so the two never skew.
  gray_encode #(.WIDTH(WIDTH)) u_enc (
    .bin  (bin_d),
    .gray (gray_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= INIT;
      gray_q <= INIT ^ (INIT >> 1);
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed and model-checked bench for a 3-bit gray_counter with INIT=0.
module tb_gray_counter;

  logic       clk = 1'b0;
  logic       rst_n, en, up, load;
  logic [2:0] load_gray, bin_q, gray_q;
  logic       wrap;

  int n_chk  = 0;
  int n_fail = 0;

  logic [2:0] eb, pg;
  logic       ew, stepped;
  logic [2:0] gexp [8];

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(3), .INIT(3'd0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .up        (up),
    .load      (load),
    .load_gray (load_gray),
    .bin_q     (bin_q),
    .gray_q    (gray_q),
    .wrap      (wrap)
  );

  function automatic logic [2:0] b2g(input logic [2:0] x);
    return x ^ (x >> 1);
  endfunction

  function automatic logic [2:0] g2b(input logic [2:0] g);
    logic [2:0] b;
    for (int i = 0; i < 3; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] b, input logic [2:0] g, input logic w);
    chk({tag, ".bin"}, 32'(bin_q), 32'(b));
    chk({tag, ".gray"}, 32'(gray_q), 32'(g));
    chk({tag, ".wrap"}, 32'(wrap), 32'(w));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    gexp = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    rst_n = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; load_gray = 3'b000;
    #1 chk3("rst_async", 3'd0, 3'd0, 1'b0);
    repeat (3) begin
      tick();
      chk3("rst_hold", 3'd0, 3'd0, 1'b0);
    end

    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk3("up_seq", 3'(k + 1), gexp[k], k == 7);
    end

    en = 1'b0;
    tick();
    chk3("hold0", 3'd0, 3'd0, 1'b0);

    rst_n = 1'b0;
    #1 chk3("rst_mid", 3'd0, 3'd0, 1'b0);
    rst_n = 1'b1; en = 1'b1; up = 1'b0;
    tick(); chk3("down_wrap", 3'b111, 3'b100, 1'b1);
    tick(); chk3("down", 3'b110, 3'b101, 1'b0);
    up = 1'b1;
    tick(); chk3("dir_flip", 3'b111, 3'b100, 1'b0);
    tick(); chk3("up_wrap", 3'b000, 3'b000, 1'b1);

    load = 1'b1; load_gray = 3'b101;
    tick(); chk3("load", 3'b110, 3'b101, 1'b0);
    load = 1'b0;
    tick(); chk3("after_load", 3'b111, 3'b100, 1'b0);
    // At all-ones with up-count enabled, load must win and suppress wrap.
    load = 1'b1; load_gray = 3'b111;
    tick(); chk3("load_wins", 3'b101, 3'b111, 1'b0);
    load = 1'b0; en = 1'b0;
    tick(); chk3("hold", 3'b101, 3'b111, 1'b0);

    rst_n = 1'b0;
    #1 rst_n = 1'b1; en = 1'b1; up = 1'b1;
    repeat (5) tick();
    chk3("pre_rst", 3'b101, 3'b111, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk3("pulse_rst", 3'd0, 3'd0, 1'b0);
    #1 rst_n = 1'b1;
    tick(); chk3("resume", 3'b001, 3'b001, 1'b0);

    eb = 3'b001; pg = 3'b001;
    for (int n = 0; n < 1000; n++) begin
      en        = 1'($urandom_range(0, 1));
      up        = 1'($urandom_range(0, 1));
      load      = ($urandom_range(0, 7) == 0);
      load_gray = 3'($urandom);
      stepped   = en && !load;
      ew        = 1'b0;
      if (load) eb = g2b(load_gray);
      else if (en && up) begin
        ew = (eb == 3'b111);
        eb = eb + 3'd1;
      end else if (en) begin
        ew = (eb == 3'b000);
        eb = eb - 3'd1;
      end
      tick();
      chk3("rand", eb, b2g(eb), ew);
      if (stepped) chk("one_bit", 32'($countones(gray_q ^ pg)), 32'd1);
      pg = b2g(eb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits; legal values are 2 to 32.
REQ-002 The block SHALL have parameter INIT, default 0, giving the binary reset value of the count.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state is updated on its rising edge.
REQ-004 Port rst_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-005 Port en, input, 1 bit, SHALL enable counting.
REQ-006 Port up, input, 1 bit, SHALL select direction: 1 counts up, 0 counts down.
REQ-007 Port load, input, 1 bit, SHALL be a synchronous load strobe.
REQ-008 Port load_gray, input, WIDTH bits, SHALL carry the load value in Gray code.
REQ-009 Port bin_q, output, WIDTH bits, SHALL be the registered binary count.
REQ-010 Port gray_q, output, WIDTH bits, SHALL be the registered Gray count, equal to bin_q XOR (bin_q >> 1).
REQ-011 Port wrap, output, 1 bit, SHALL be a registered one-cycle pulse flagging a terminal-count rollover.

Function
REQ-012 The block SHALL update each cycle in fixed priority order: load, then en, then hold.
REQ-013 When load=1, the block SHALL take gray_q = load_gray and bin_q = Gray-to-binary(load_gray), where bit i is the XOR of load_gray bits WIDTH-1 down to i; wrap SHALL be 0.
REQ-014 When load=0, en=1 and up=1, bin_q SHALL become bin_q+1 modulo 2^WIDTH.
REQ-015 When load=0, en=1 and up=0, bin_q SHALL become bin_q-1 modulo 2^WIDTH.
REQ-016 wrap SHALL be 1 for one cycle after an up-count from all-ones, or after a down-count from zero; otherwise it SHALL be 0.
REQ-017 When load=0 and en=0, bin_q and gray_q SHALL hold and wrap SHALL be 0.
REQ-018 Latency from input sampling to outputs SHALL be one cycle; there SHALL be no combinational path from any input to any output.
REQ-019 bin_q and gray_q SHALL update on the same edge, so they never disagree for a cycle.
REQ-020 Between successive enabled counts, gray_q SHALL change in exactly one bit, including across the wrap boundary.
REQ-021 When load and en are asserted together, load SHALL win and the count SHALL NOT be applied that cycle.
REQ-022 A change of up while en=1 SHALL take effect on the next edge with no dead cycle.
REQ-023 load_gray SHALL be accepted unchecked; every WIDTH-bit pattern is a valid Gray code.

Reset
REQ-024 Assertion of rst_n=0 SHALL immediately, independent of clk, set bin_q=INIT, gray_q=INIT XOR (INIT>>1) and wrap=0.
REQ-025 Reset asserted mid-count SHALL discard any pending load or count.
REQ-026 On the first rising edge after rst_n deasserts, the block SHALL act on its inputs normally.

Structure
REQ-027 Package gray_pkg SHALL hold the constant GRAY_DEFAULT_WIDTH = 4 and the automatic functions bin2gray and gray2bin, parameterised by width.
REQ-028 The block SHALL instantiate one sub-module, gray_encode (combinational, parameter WIDTH, bin in / gray out), to drive the next-state gray_q from the next-state bin_q.
REQ-029 Gray-to-binary conversion on the load path SHALL use gray2bin from gray_pkg.
REQ-030 Expected size is 120-250 lines of RTL including the sub-module.

Verification
REQ-031 The bench SHALL use WIDTH=3 and INIT=0; with rst_n held low -> bin_q=000, gray_q=000, wrap=0, including while clk toggles.
REQ-032 With en=1, up=1 for 9 cycles -> gray_q = 000,001,011,010,110,111,101,100,000; wrap=1 only on the cycle gray_q returns to 000.
REQ-033 With en=1, up=0 from reset -> bin_q = 111, gray_q = 100, wrap=1 after one edge; then bin_q = 110, wrap=0.
REQ-034 With load=1, load_gray=101, en=1 for one cycle -> bin_q=110, gray_q=101, wrap=0; the next up-count -> bin_q=111, gray_q=100.
REQ-035 rst_n pulsed low mid-count, between clock edges, at bin_q=101 -> outputs go to 000 before the next clk edge; counting resumes at 001 after deassert.
REQ-036 A free-running random mix of en, up and load for 1000 cycles against a reference model -> every gray_q equals bin2gray(bin_q), and each enabled non-load step changes exactly one gray_q bit.
